// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and saturating kill counter.
// Define PIPE_SKID_EN for the two-entry skid build with a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned KCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [1:0]        occupancy,
    output logic [KCNT_W-1:0] kill_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_main, w_main_nxt;
    logic [KCNT_W-1:0]   r_kill, w_kill_nxt;
    logic                w_main_valid, w_skid_valid;
    logic                w_in_fire, w_out_fire;
    logic [1:0]          w_kill_inc;
    logic [KCNT_W:0]     w_kill_inc_ext, w_kill_sum;

`ifdef PIPE_SKID_EN
    logic [WIDTH-1:0]    r_skid, w_skid_nxt;
    logic                r_in_ready;

    assign w_skid_valid = (r_state == TWO);
    assign in_ready     = r_in_ready;
`else
    assign w_skid_valid = 1'b0;
    assign in_ready     = !w_main_valid || out_ready;
`endif

    assign w_main_valid = (r_state != EMPTY);
    assign w_in_fire    = in_valid && in_ready;
    assign w_out_fire   = w_main_valid && out_ready;

    assign out_valid = w_main_valid;
    assign out_data  = r_main;
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
    assign kill_cnt  = r_kill;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
`ifdef PIPE_SKID_EN
        w_skid_nxt  = r_skid;
`endif
        // Flush wins over both handshakes; payloads keep their old contents.
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_main_nxt  = in_data;
                        w_state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
`ifdef PIPE_SKID_EN
                    end else if (w_in_fire) begin
                        w_skid_nxt  = in_data;
                        w_state_nxt = TWO;
`endif
                    end
                end
`ifdef PIPE_SKID_EN
                TWO: begin
                    if (w_out_fire) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = ONE;
                    end
                end
`endif
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // Entries killed: head unless it left this cycle, plus the skid entry.
    always_comb begin
        w_kill_inc          = {1'b0, w_main_valid && !w_out_fire} + {1'b0, w_skid_valid};
        w_kill_inc_ext      = '0;
        w_kill_inc_ext[1:0] = w_kill_inc;
        w_kill_sum          = {1'b0, r_kill} + w_kill_inc_ext;
        w_kill_nxt          = r_kill;
        if (flush) begin
            w_kill_nxt = w_kill_sum[KCNT_W] ? '1 : w_kill_sum[KCNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_kill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

`ifdef PIPE_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_skid     <= w_skid_nxt;
            r_in_ready <= (w_state_nxt != TWO);
        end
    end
`endif

endmodule
